pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Consumer of the hazard detection unit's Stall_IF/Stall_ID/Flush_EX requests, plus branch/jump redirects and a multi-cycle mult/div busy handshake.
- Arbitrates all requests into per-stage register enables and flushes for PC, IF/ID, ID/EX and EX/MEM in the 5-stage MIPS pipeline.
- Sequential part: a mult/div wait state machine with a timeout, and optional performance counters.

Parameters:
- MD_TIMEOUT, 64: maximum cycles in MD_WAIT before forced release.
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Stall_IF  input  1  load-use stall request for PC.
- Stall_ID  input  1  load-use stall request for IF/ID.
- Flush_EX  input  1  load-use bubble request for ID/EX.
- Branch_Taken_EX  input  1  taken branch resolved in EX; PC loads the target this cycle.
- Jump_ID  input  1  jump decoded in ID; PC loads the target this cycle.
- MD_Start_EX  input  1  one-cycle pulse when a multi-cycle mult/div enters EX.
- MD_Done  input  1  mult/div result valid this cycle.
- PC_Enable  output  1  PC register load enable.
- IFID_Enable  output  1  IF/ID register load enable.
- IFID_Flush  output  1  IF/ID loads a NOP.
- IDEX_Enable  output  1  ID/EX register load enable.
- IDEX_Flush  output  1  ID/EX loads a bubble (control signals zeroed).
- EXMEM_Flush  output  1  EX/MEM loads a bubble.
- MD_Busy  output  1  high while in MD_WAIT.
- MD_Error  output  1  sticky flag: timeout occurred; cleared only by reset.

Behaviour:
- Reset, asynchronous and active-high:
  - state=RUN, wait counter=0, MD_Error=0, perf counters=0.
  - While reset is high: PC_Enable=0, IFID_Enable=0, IDEX_Enable=0, IFID_Flush=1, IDEX_Flush=1, EXMEM_Flush=1, MD_Busy=0.
- Enable/flush outputs are combinational from state and inputs so they act in the same cycle. State and counters update on the rising clk edge.
- States: RUN and MD_WAIT.
- RUN, priority highest first:
  1. Branch_Taken_EX=1:
     - PC_Enable=1, IFID_Enable=1, IFID_Flush=1, IDEX_Enable=1, IDEX_Flush=1, EXMEM_Flush=0.
     - Overrides load-use stall and Jump_ID, since those instructions are wrong-path.
  2. MD_Start_EX=1:
     - Next state MD_WAIT.
     - This cycle: PC_Enable=0, IFID_Enable=0, IDEX_Enable=0, EXMEM_Flush=1.
  3. Stall_IF or Stall_ID or Flush_EX:
     - PC_Enable=!Stall_IF, IFID_Enable=!Stall_ID, IDEX_Enable=1, IDEX_Flush=Flush_EX.
     - If Jump_ID is also high, the jump is ignored this cycle; it re-presents the next cycle.
  4. Jump_ID=1: all enables=1, IFID_Flush=1.
  5. Otherwise: all enables=1, all flushes=0.
- MD_WAIT:
  - PC_Enable=IFID_Enable=IDEX_Enable=0; EXMEM_Flush=1; MD_Busy=1.
  - Branch_Taken_EX, Jump_ID and all load-use inputs are ignored.
  - Wait counter increments each cycle.
  - MD_Done=1: outputs as in RUN with no requests (all enables=1, EXMEM_Flush=0); next state RUN; counter cleared.
  - Counter reaching MD_TIMEOUT-1 without MD_Done: same release as MD_Done, and MD_Error set.
- MD_Start_EX and MD_Done high together in RUN: treated as a zero-wait op; no state change, no stall.
- Latency:
  - Release occurs in the MD_Done cycle.
  - Minimum MD stall is 1 cycle (Start cycle) plus N wait cycles.
- Reset mid-MD_WAIT: immediate return to RUN; MD_Error cleared.

Optional Feature:
- Macro: STALL_PERF_COUNTERS_EN.
- When defined, adds outputs Stall_Cycles and Flush_Count, each CNT_WIDTH bits.
  - Stall_Cycles increments every cycle with PC_Enable=0 while reset is low.
  - Flush_Count increments every cycle with IFID_Flush or IDEX_Flush high while reset is low.
  - Both saturate at all-ones and reset to 0.
- When undefined, the ports and logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset test: assert reset mid-cycle -> outputs take reset values immediately (before the next edge). Release reset with no requests -> next cycle all enables=1, all flushes=0.
- Load-use test: Stall_IF=Stall_ID=Flush_EX=1 for 1 cycle -> PC_Enable=0, IFID_Enable=0, IDEX_Flush=1 that cycle. Following cycle -> all enables=1.
- Branch over stall: Branch_Taken_EX=1 with Stall_IF=Stall_ID=Flush_EX=1 and Jump_ID=1 -> PC_Enable=1, IFID_Flush=1, IDEX_Flush=1.
- Mult/div handshake: MD_Start_EX pulse, then MD_Done 5 cycles later -> MD_Busy=1 for 5 cycles, EXMEM_Flush=1 for 6 cycles, release in the MD_Done cycle, MD_Error=0.
- Timeout: MD_TIMEOUT=8, MD_Start_EX with no MD_Done -> forced release after 8 cycles in MD_WAIT, MD_Error=1 until reset. Reset during a later MD_WAIT -> state RUN, MD_Error=0.
- With STALL_PERF_COUNTERS_EN: 3 load-use stalls + 1 branch -> Stall_Cycles=3, Flush_Count=4.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Stall/flush arbiter for the 5-stage MIPS pipeline, with a mult/div wait FSM and timeout.
// Optional saturating performance counters are enabled by defining STALL_PERF_COUNTERS_EN.
module pipeline_stall_controller #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic Stall_IF,
    input  logic Stall_ID,
    input  logic Flush_EX,
    input  logic Branch_Taken_EX,
    input  logic Jump_ID,
    input  logic MD_Start_EX,
    input  logic MD_Done,
    output logic PC_Enable,
    output logic IFID_Enable,
    output logic IFID_Flush,
    output logic IDEX_Enable,
    output logic IDEX_Flush,
    output logic EXMEM_Flush,
    output logic MD_Busy,
    output logic MD_Error
`ifdef STALL_PERF_COUNTERS_EN
    ,
    output logic [CNT_WIDTH-1:0] Stall_Cycles,
    output logic [CNT_WIDTH-1:0] Flush_Count
`endif
);

    localparam int WCNT_W = $clog2(MD_TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MD_TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [WCNT_W-1:0] w_wait_cnt_nxt;
    logic              r_md_error;
    logic              w_err_set;
    logic              w_load_use;
    logic              w_md_release;

    assign w_load_use   = Stall_IF | Stall_ID | Flush_EX;
    assign w_md_release = MD_Done | (r_wait_cnt == WCNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_md_error <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_err_set) begin
                r_md_error <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_err_set      = 1'b0;
        PC_Enable      = 1'b1;
        IFID_Enable    = 1'b1;
        IFID_Flush     = 1'b0;
        IDEX_Enable    = 1'b1;
        IDEX_Flush     = 1'b0;
        EXMEM_Flush    = 1'b0;
        MD_Busy        = 1'b0;

        if (reset) begin
            // Hold every stage and inject bubbles for as long as reset is asserted.
            w_state_nxt    = ST_RUN;
            w_wait_cnt_nxt = '0;
            PC_Enable      = 1'b0;
            IFID_Enable    = 1'b0;
            IDEX_Enable    = 1'b0;
            IFID_Flush     = 1'b1;
            IDEX_Flush     = 1'b1;
            EXMEM_Flush    = 1'b1;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    w_wait_cnt_nxt = '0;
                    if (Branch_Taken_EX) begin
                        IFID_Flush = 1'b1;
                        IDEX_Flush = 1'b1;
                    end else if (MD_Start_EX && !MD_Done) begin
                        w_state_nxt = ST_MD_WAIT;
                        PC_Enable   = 1'b0;
                        IFID_Enable = 1'b0;
                        IDEX_Enable = 1'b0;
                        EXMEM_Flush = 1'b1;
                    end else if (w_load_use) begin
                        // A concurrent jump is dropped here and re-presents next cycle.
                        PC_Enable   = !Stall_IF;
                        IFID_Enable = !Stall_ID;
                        IDEX_Flush  = Flush_EX;
                    end else if (Jump_ID) begin
                        IFID_Flush = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    if (w_md_release) begin
                        w_state_nxt    = ST_RUN;
                        w_wait_cnt_nxt = '0;
                        w_err_set      = !MD_Done;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + WCNT_ONE;
                        PC_Enable      = 1'b0;
                        IFID_Enable    = 1'b0;
                        IDEX_Enable    = 1'b0;
                        EXMEM_Flush    = 1'b1;
                        MD_Busy        = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    assign MD_Error = r_md_error;

`ifdef STALL_PERF_COUNTERS_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [CNT_WIDTH-1:0] r_flush_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!PC_Enable) begin
                r_stall_cycles <= sat_inc(r_stall_cycles);
            end
            if (IFID_Flush || IDEX_Flush) begin
                r_flush_count <= sat_inc(r_flush_count);
            end
        end
    end

    assign Stall_Cycles = r_stall_cycles;
    assign Flush_Count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_pipeline_stall_controller;

    localparam int MDT = 8;
    localparam int CW  = 32;

    localparam logic [7:0] S_IDLE = 8'b0000_0000;
    localparam logic [7:0] S_RST  = 8'b1000_0000;
    localparam logic [7:0] S_LU   = 8'b0111_0000;
    localparam logic [7:0] S_BRAL = 8'b0111_1100;
    localparam logic [7:0] S_JMP  = 8'b0000_0100;
    localparam logic [7:0] S_LUJ  = 8'b0111_0100;
    localparam logic [7:0] S_ST   = 8'b0000_0010;
    localparam logic [7:0] S_DN   = 8'b0000_0001;
    localparam logic [7:0] S_STDN = 8'b0000_0011;

    logic clk = 1'b0;
    logic reset, Stall_IF, Stall_ID, Flush_EX, Branch_Taken_EX, Jump_ID, MD_Start_EX, MD_Done;
    logic PC_Enable, IFID_Enable, IFID_Flush, IDEX_Enable, IDEX_Flush, EXMEM_Flush, MD_Busy, MD_Error;
`ifdef STALL_PERF_COUNTERS_EN
    logic [CW-1:0] Stall_Cycles, Flush_Count;
`endif

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MD_TIMEOUT(MDT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .Stall_IF(Stall_IF), .Stall_ID(Stall_ID), .Flush_EX(Flush_EX),
        .Branch_Taken_EX(Branch_Taken_EX), .Jump_ID(Jump_ID),
        .MD_Start_EX(MD_Start_EX), .MD_Done(MD_Done),
        .PC_Enable(PC_Enable), .IFID_Enable(IFID_Enable), .IFID_Flush(IFID_Flush),
        .IDEX_Enable(IDEX_Enable), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
        .MD_Busy(MD_Busy), .MD_Error(MD_Error)
`ifdef STALL_PERF_COUNTERS_EN
        , .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: are we waiting on mult/div, how many wait cycles so far.
    bit m_in_md  = 0;
    int m_waited = 0;
    bit m_err    = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    logic obs_busy, obs_exf;
    int   busy_cnt, exf_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {PC_En, IFID_En, IFID_Fl, IDEX_En, IDEX_Fl, EXMEM_Fl, Busy} for stimulus s.
    function automatic logic [6:0] exp_vec(input logic [7:0] s);
        logic sif, sid, fex, br, jmp, st, dn;
        {sif, sid, fex, br, jmp, st, dn} = s[6:0];
        if (s[7]) return 7'b0010110;
        if (m_in_md) begin
            if (dn || m_waited == MDT - 1) return 7'b1101000;
            return 7'b0000011;
        end
        if (br) return 7'b1111100;
        if (st && !dn) return 7'b0000010;
        if (sif || sid || fex) return {~sif, ~sid, 1'b0, 1'b1, fex, 1'b0, 1'b0};
        if (jmp) return 7'b1111000;
        return 7'b1101000;
    endfunction

    task automatic step(input logic [7:0] s);
        logic [6:0] e, o;
        {reset, Stall_IF, Stall_ID, Flush_EX, Branch_Taken_EX, Jump_ID, MD_Start_EX, MD_Done} = s;
        #2;
        if (s[7]) begin
            m_in_md = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end
        e = exp_vec(s);
        o = {PC_Enable, IFID_Enable, IFID_Flush, IDEX_Enable, IDEX_Flush, EXMEM_Flush, MD_Busy};
        obs_busy = MD_Busy;
        obs_exf  = EXMEM_Flush;
        chk("ctl_outputs", {25'b0, o}, {25'b0, e});
        chk("md_error", {31'b0, MD_Error}, {31'b0, m_err});
`ifdef STALL_PERF_COUNTERS_EN
        chk("stall_cycles", Stall_Cycles, m_stall);
        chk("flush_count", Flush_Count, m_flush);
`endif
        @(posedge clk);
        #1;
        if (!s[7]) begin
            if (!e[6]) m_stall++;
            if (e[4] || e[2]) m_flush++;
            if (m_in_md) begin
                if (s[0] || m_waited == MDT - 1) begin
                    if (!s[0]) m_err = 1;
                    m_in_md = 0;
                    m_waited = 0;
                end else begin
                    m_waited++;
                end
            end else if (!s[3] && s[1] && !s[0]) begin
                m_in_md = 1;
                m_waited = 0;
            end
        end
    endtask

    task automatic step_count(input logic [7:0] s);
        step(s);
        busy_cnt += int'(obs_busy);
        exf_cnt  += int'(obs_exf);
    endtask

    initial begin
        logic [7:0] s;
        // Reset and release
        step(S_RST);
        step(S_RST);
        step(S_IDLE);
        step(S_IDLE);
        // Load-use, branch over everything, jump, jump blocked by load-use
        step(S_LU);
        step(S_IDLE);
        step(S_BRAL);
        step(S_JMP);
        step(S_LUJ);
        step(8'b0001_0000);
        step(8'b0100_0000);
        // Reset asserted mid-run, then released
        step(S_RST);
        step(S_IDLE);
        // Mult/div handshake: five wait cycles then done
        busy_cnt = 0; exf_cnt = 0;
        step_count(S_ST);
        step_count(S_IDLE);
        step_count(S_BRAL);
        step_count(S_JMP);
        step_count(S_IDLE);
        step_count(S_IDLE);
        step_count(S_DN);
        chk("md_busy_cycles", busy_cnt, 5);
        chk("md_exmem_flush_cycles", exf_cnt, 6);
        chk("md_error_after_done", {31'b0, MD_Error}, 32'd0);
        // Zero-wait op
        step(S_STDN);
        step(S_IDLE);
        // Timeout
        busy_cnt = 0; exf_cnt = 0;
        step_count(S_ST);
        repeat (MDT) step_count(S_IDLE);
        chk("timeout_busy_cycles", busy_cnt, MDT - 1);
        step(S_IDLE);
        chk("md_error_sticky", {31'b0, MD_Error}, 32'd1);
        repeat (3) step(S_IDLE);
        step(S_ST);
        step(S_IDLE);
        step(S_IDLE);
        step(S_RST);
        chk("reset_mid_wait_busy", {31'b0, MD_Busy}, 32'd0);
        chk("reset_mid_wait_error", {31'b0, MD_Error}, 32'd0);
        step(S_IDLE);
`ifdef STALL_PERF_COUNTERS_EN
        step(S_RST);
        repeat (3) step(S_LU);
        step(8'b0000_1000);
        step(S_IDLE);
        chk("perf_stall_total", Stall_Cycles, 32'd3);
        chk("perf_flush_total", Flush_Count, 32'd4);
`endif
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            s = S_IDLE;
            s[7] = ($urandom_range(0, 99) == 0);
            s[6] = ($urandom_range(0, 4) == 0);
            s[5] = ($urandom_range(0, 4) == 0);
            s[4] = ($urandom_range(0, 4) == 0);
            s[3] = ($urandom_range(0, 7) == 0);
            s[2] = ($urandom_range(0, 5) == 0);
            s[1] = ($urandom_range(0, 9) == 0);
            s[0] = ($urandom_range(0, 11) == 0);
            step(s);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
